// File: rtl/axil_mem_arbiter_pkg.sv
// Shared types for the AXI-Lite to single-port memory arbiter: FSM states,
// arbitration pointer and AXI response codes.
package axil_mem_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_MEM_RD = 3'd1,
      ST_MEM_WR = 3'd2,
      ST_R_RESP = 3'd3,
      ST_B_RESP = 3'd4
   } state_e;

   typedef enum logic {
      PRIO_READ  = 1'b0,
      PRIO_WRITE = 1'b1
   } prio_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // The read side takes the bus when it is alone or when it holds the priority token.
   function automatic logic read_wins(input logic rd_pend, input logic wr_pend, input prio_e prio);
      return rd_pend && (!wr_pend || (prio == PRIO_READ));
   endfunction

endpackage

// File: rtl/axil_req_holder.sv
// One-entry valid/ready holding register. The ready output is registered so it
// is low during reset and follows the next-cycle full/enable state.
module axil_req_holder #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         en,
   input  logic         clr,
   output logic         full,
   output logic [W-1:0] data
);

   logic         full_q, full_d;
   logic         ready_q, ready_d;
   logic [W-1:0] data_q, data_d;

   // Capture on handshake, release on clear; both never coincide since ready implies empty.
   always_comb begin
      full_d = full_q;
      data_d = data_q;
      if (clr) begin
         full_d = 1'b0;
      end else if (in_valid && ready_q) begin
         full_d = 1'b1;
         data_d = in_data;
      end else begin
         full_d = full_q;
      end
      ready_d = en && !full_d;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         full_q  <= 1'b0;
         ready_q <= 1'b0;
         data_q  <= {W{1'b0}};
      end else begin
         full_q  <= full_d;
         ready_q <= ready_d;
         data_q  <= data_d;
      end
   end

   assign in_ready = ready_q;
   assign full     = full_q;
   assign data     = data_q;

endmodule

// File: rtl/axil_mem_arbiter.sv
// Bridges independent AXI-Lite read/write channels onto one shared memory bus
// with round-robin arbitration, one outstanding access and a timeout abort.
module axil_mem_arbiter
   import axil_mem_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    AWvalid,
   output logic                    AWready,
   input  logic [ADDR_WIDTH-1:0]   AWdata,
   input  logic                    Wvalid,
   output logic                    Wready,
   input  logic [DATA_WIDTH-1:0]   Wdata,
   input  logic [DATA_WIDTH/8-1:0] Wstrb,
   output logic                    Bvalid,
   input  logic                    Bready,
   output logic [1:0]              Bresp,
   input  logic                    ARvalid,
   output logic                    ARready,
   input  logic [ADDR_WIDTH-1:0]   ARdata,
   output logic                    Rvalid,
   input  logic                    RReady,
   output logic [DATA_WIDTH-1:0]   Rdata,
   output logic [1:0]              Rresp,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic [DATA_WIDTH-1:0]   mem_write_data,
   output logic [DATA_WIDTH/8-1:0] mem_strb,
   input  logic [DATA_WIDTH-1:0]   mem_read_data,
   input  logic                    mem_response
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TERM = (TIMEOUT_CYCLES > 1) ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};
   localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   state_e                   state_q, state_d;
   prio_e                    prio_q, prio_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     mem_read_q, mem_read_d, mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
   logic [STRB_W-1:0]        mem_strb_q, mem_strb_d;
   logic                     rvalid_q, rvalid_d, bvalid_q, bvalid_d;
   logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
   logic [1:0]               rresp_q, rresp_d, bresp_q, bresp_d;

   logic                     aw_full, w_full, ar_full, rd_clr, wr_clr, ar_en;
   logic [ADDR_WIDTH-1:0]    aw_addr, ar_addr;
   logic [DATA_WIDTH+STRB_W-1:0] w_bus;
   logic                     rd_pend, wr_pend, timeout_hit;

   axil_req_holder #(.W(ADDR_WIDTH)) u_aw (
      .clk(clk), .rstn(rstn), .in_valid(AWvalid), .in_ready(AWready), .in_data(AWdata),
      .en(1'b1), .clr(wr_clr), .full(aw_full), .data(aw_addr));

   axil_req_holder #(.W(DATA_WIDTH + STRB_W)) u_w (
      .clk(clk), .rstn(rstn), .in_valid(Wvalid), .in_ready(Wready), .in_data({Wstrb, Wdata}),
      .en(1'b1), .clr(wr_clr), .full(w_full), .data(w_bus));

   // Reads are only accepted when the arbiter will be idle next cycle.
   axil_req_holder #(.W(ADDR_WIDTH)) u_ar (
      .clk(clk), .rstn(rstn), .in_valid(ARvalid), .in_ready(ARready), .in_data(ARdata),
      .en(ar_en), .clr(rd_clr), .full(ar_full), .data(ar_addr));

   assign ar_en       = (state_d == ST_IDLE);
   assign rd_pend     = ar_full;
   assign wr_pend     = aw_full && w_full;
   assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_TERM);

   // Next-state and registered-output computation; mem_response wins over a same-cycle timeout.
   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      cnt_d       = cnt_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_strb_d  = mem_strb_q;
      rvalid_d    = rvalid_q;
      rdata_d     = rdata_q;
      rresp_d     = rresp_q;
      bvalid_d    = bvalid_q;
      bresp_d     = bresp_q;
      rd_clr      = 1'b0;
      wr_clr      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = {CNT_W{1'b0}};
            if (read_wins(rd_pend, wr_pend, prio_q)) begin
               state_d    = ST_MEM_RD;
               mem_read_d = 1'b1;
               mem_addr_d = ar_addr;
               prio_d     = wr_pend ? PRIO_WRITE : prio_q;
            end else if (wr_pend) begin
               state_d     = ST_MEM_WR;
               mem_write_d = 1'b1;
               mem_addr_d  = aw_addr;
               mem_wdata_d = w_bus[DATA_WIDTH-1:0];
               mem_strb_d  = w_bus[DATA_WIDTH+STRB_W-1:DATA_WIDTH];
               prio_d      = rd_pend ? PRIO_READ : prio_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MEM_RD: begin
            if (mem_response || timeout_hit) begin
               state_d    = ST_R_RESP;
               mem_read_d = 1'b0;
               rvalid_d   = 1'b1;
               rd_clr     = 1'b1;
               rdata_d    = mem_response ? mem_read_data : {DATA_WIDTH{1'b0}};
               rresp_d    = mem_response ? RESP_OKAY : RESP_SLVERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_MEM_WR: begin
            if (mem_response || timeout_hit) begin
               state_d     = ST_B_RESP;
               mem_write_d = 1'b0;
               bvalid_d    = 1'b1;
               wr_clr      = 1'b1;
               bresp_d     = mem_response ? RESP_OKAY : RESP_SLVERR;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_R_RESP: begin
            if (RReady) begin
               rvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_R_RESP;
            end
         end
         ST_B_RESP: begin
            if (Bready) begin
               bvalid_d = 1'b0;
               state_d  = ST_IDLE;
            end else begin
               state_d = ST_B_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, arbitration and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         prio_q      <= PRIO_READ;
         cnt_q       <= {CNT_W{1'b0}};
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= {ADDR_WIDTH{1'b0}};
         mem_wdata_q <= {DATA_WIDTH{1'b0}};
         mem_strb_q  <= {STRB_W{1'b0}};
         rvalid_q    <= 1'b0;
         rdata_q     <= {DATA_WIDTH{1'b0}};
         rresp_q     <= 2'b00;
         bvalid_q    <= 1'b0;
         bresp_q     <= 2'b00;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         cnt_q       <= cnt_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_strb_q  <= mem_strb_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         rresp_q     <= rresp_d;
         bvalid_q    <= bvalid_d;
         bresp_q     <= bresp_d;
      end
   end

   assign mem_read       = mem_read_q;
   assign mem_write      = mem_write_q;
   assign mem_address    = mem_addr_q;
   assign mem_write_data = mem_wdata_q;
   assign mem_strb       = mem_strb_q;
   assign Rvalid         = rvalid_q;
   assign Rdata          = rdata_q;
   assign Rresp          = rresp_q;
   assign Bvalid         = bvalid_q;
   assign Bresp          = bresp_q;

endmodule

// File: doc/axil_mem_arbiter.md
Name: axil_mem_arbiter

Overview:
- Bridges the core's AXI4-Lite style master port (independent AW/W/B and AR/R channels) onto the single shared memory bus of the Controller (read strobe, write strobe, address, write data, response).
- Replaces the combinational address mux in the top-level wrapper.
- Arbitrates read against write with round-robin priority and enforces one outstanding memory transaction.
- Supervises each memory access with a timeout so a dead bus returns an error instead of hanging the core.

Parameters:
- ADDR_WIDTH, 32, address width on both sides.
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1024, cycles without mem_response before the access is aborted with SLVERR; 0 disables the timeout.

Ports:
- clk  in  1  single clock.
- rstn  in  1  asynchronous active-low reset.
- AWvalid  in  1  write address valid.
- AWready  out  1  write address accepted.
- AWdata  in  ADDR_WIDTH  write address.
- Wvalid  in  1  write data valid.
- Wready  out  1  write data accepted.
- Wdata  in  DATA_WIDTH  write data.
- Wstrb  in  DATA_WIDTH/8  byte enables.
- Bvalid  out  1  write response valid.
- Bready  in  1  write response accepted.
- Bresp  out  2  00 OKAY, 10 SLVERR.
- ARvalid  in  1  read address valid.
- ARready  out  1  read address accepted.
- ARdata  in  ADDR_WIDTH  read address.
- Rvalid  out  1  read data valid.
- RReady  in  1  read data accepted.
- Rdata  out  DATA_WIDTH  read data.
- Rresp  out  2  read response code.
- mem_read  out  1  memory read strobe, held until response.
- mem_write  out  1  memory write strobe, held until response.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_write_data  out  DATA_WIDTH  memory write data.
- mem_strb  out  DATA_WIDTH/8  memory byte enables.
- mem_read_data  in  DATA_WIDTH  memory read data, valid while mem_response=1.
- mem_response  in  1  one-cycle completion pulse from memory.

Behaviour:
- Reset (rstn=0, asynchronous):
  - All outputs 0, including Rdata and Bresp/Rresp.
  - Capture flags cleared, state IDLE, priority pointer = READ, timeout counter = 0.
- AW/W capture:
  - AWready=1 while the AW holding register is empty; the handshake latches AWdata.
  - W is captured independently the same way (Wready=1 while empty; latches Wdata and Wstrb).
  - AW and W may arrive in either order or in the same cycle.
  - A write is pending when both holding registers are full.
- AR capture: ARready=1 only in IDLE with the AR holding register empty. A read is pending when AR is full.
- State machine, registered outputs:
  - IDLE → MEM_RD when only a read is pending.
  - IDLE → MEM_WR when only a write is pending.
  - IDLE, both pending: the side named by the priority pointer wins, and the pointer flips to the other side.
  - Entering MEM_RD/MEM_WR, the next cycle drives mem_read or mem_write=1 with address (and data/strobe) from the holding registers. The strobe stays high until mem_response.
  - MEM_RD on mem_response → R_RESP:
    - Strobe drops the same edge.
    - Rdata latches mem_read_data; Rvalid=1, Rresp=00.
    - AR holding register frees.
  - MEM_WR on mem_response → B_RESP: Bvalid=1, Bresp=00; AW and W holding registers free.
  - R_RESP: hold until RReady=1 → IDLE. B_RESP: hold until Bready=1 → IDLE.
  - Timeout counter resets on entry to MEM_RD/MEM_WR and increments each cycle in those states.
  - Timeout abort: when the counter reaches TIMEOUT_CYCLES-1 without mem_response, drop the strobe and go to R_RESP or B_RESP. Rdata=0, response = 10.
- Latency: request capture → memory strobe = 2 cycles minimum; mem_response → Rvalid/Bvalid = 1 cycle.
- Boundaries:
  - mem_response in IDLE or a RESP state is ignored.
  - mem_response arriving in the same cycle as the timeout terminal count counts as success.
  - Only one strobe is ever high, and never both.
  - A new AW/W may be captured during MEM_RD; it waits for IDLE.
  - Reset mid-transaction aborts immediately, with no response issued.

Decomposition:
- Shared package holds the state encoding (IDLE, MEM_RD, MEM_WR, R_RESP, B_RESP) and the response constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- One natural sub-module: axil_req_holder, a one-entry valid/ready holding register, instantiated for AW, W and AR.

Test Plan:
- Read: AR addr 0x100; memory responds 3 cycles after mem_read with 0xCAFEBABE → mem_address=0x100, Rvalid with Rdata=0xCAFEBABE, Rresp=00. mem_read high exactly 3 cycles.
- Write with W before AW: W 0x12345678, strb 0xF one cycle before AW 0x200 → single mem_write with address 0x200, data 0x12345678, strb 0xF; Bvalid with Bresp=00.
- Simultaneous AR 0x10 and AW/W 0x20 twice in a row → first pair served read-then-write, second pair write-then-read (round-robin). Never both strobes high.
- Timeout with TIMEOUT_CYCLES=8 and no mem_response → mem_read drops after 8 cycles; Rvalid with Rresp=10, Rdata=0.
- Backpressure: RReady held 0 for 5 cycles → Rvalid/Rdata stable. A new ARvalid during that time is not accepted (ARready=0).
- Async reset asserted mid-MEM_WR → all outputs 0 immediately. After release, no Bvalid appears and the next read completes normally.
